// File: rtl/ir_transmitter_pkg.sv
// Shared state encoding, counter widths and 27 MHz timing constants for the IR transmitter.
package ir_transmitter_pkg;

  // Timing for a 27 MHz system clock
  localparam int unsigned CLOCK_HZ_DEF     = 27_000_000;
  localparam int unsigned UNIT_CYCLES_DEF  = 16_200;     // 0.6 ms protocol unit T
  localparam int unsigned CARRIER_HALF_DEF = 338;        // ~40 kHz carrier half-period
  localparam int unsigned FRAME_CYCLES_DEF = 1_215_000;  // 45 ms frame start-to-start
  localparam int unsigned REPEATS_DEF      = 3;

  // Command and counter widths
  localparam int unsigned CMD_W          = 12;
  localparam int unsigned FRAME_CNT_W    = 21;
  localparam int unsigned UNIT_CNT_W     = 16;
  localparam int unsigned BIT_IDX_W      = 4;
  localparam int unsigned REP_CNT_W      = 8;
  localparam int unsigned CARRIER_CNT_W  = 16;

  // Start mark length in units, and worst-case frame length in units (all ones)
  localparam int unsigned START_UNITS    = 4;
  localparam int unsigned WORST_UNITS    = 41;

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    SPACE,
    BIT_MARK,
    FRAME_GAP
  } ir_state_e;

  // Command word as produced by main_fsm
  typedef struct packed {
    logic [3:0] angle;
    logic [7:0] magnitude;
  } move_cmd_t;

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier that restarts high on the first cycle run is asserted.
module ir_carrier_gen
  import ir_transmitter_pkg::*;
#(
  parameter int unsigned CARRIER_HALF = CARRIER_HALF_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic carrier
);

  localparam logic [CARRIER_CNT_W-1:0] HALF_LAST = CARRIER_CNT_W'(CARRIER_HALF - 1);

  logic [CARRIER_CNT_W-1:0] half_cnt;
  logic                     level;

  // Phase is parked high while idle so every mark begins with a high half-period
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
      level    <= 1'b1;
    end else if (!run) begin
      half_cnt <= '0;
      level    <= 1'b1;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      level    <= ~level;
    end else begin
      half_cnt <= half_cnt + CARRIER_CNT_W'(1);
    end
  end

  assign carrier = run & level;

endmodule

// File: rtl/ir_transmitter.sv
// Sends a latched 12-bit command as REPEATS pulse-width coded IR frames on a modulated carrier.
module ir_transmitter
  import ir_transmitter_pkg::*;
#(
  parameter int unsigned CLOCK_HZ     = CLOCK_HZ_DEF,
  parameter int unsigned UNIT_CYCLES  = UNIT_CYCLES_DEF,
  parameter int unsigned CARRIER_HALF = CARRIER_HALF_DEF,
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned REPEATS      = REPEATS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             transmit,
  input  logic [CMD_W-1:0] move_command,
  output logic             ir_signal,
  output logic             busy,
  output logic             done
);

  localparam logic [UNIT_CNT_W-1:0]  START_LAST = UNIT_CNT_W'(START_UNITS * UNIT_CYCLES - 1);
  localparam logic [UNIT_CNT_W-1:0]  UNIT_LAST  = UNIT_CNT_W'(UNIT_CYCLES - 1);
  localparam logic [UNIT_CNT_W-1:0]  ONE_LAST   = UNIT_CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_CYCLES - 1);
  localparam logic [REP_CNT_W-1:0]   LAST_REP   = REP_CNT_W'(REPEATS - 1);
  localparam logic [BIT_IDX_W-1:0]   ALL_BITS   = BIT_IDX_W'(CMD_W);

  // Reject parameter sets whose frame cannot fit its period or whose counters would wrap
  if ((WORST_UNITS * UNIT_CYCLES > FRAME_CYCLES) ||
      (FRAME_CYCLES > (1 << FRAME_CNT_W)) ||
      (START_UNITS * UNIT_CYCLES > (1 << UNIT_CNT_W)) ||
      (CARRIER_HALF == 0) || (2 * CARRIER_HALF >= CLOCK_HZ) ||
      (REPEATS == 0) || (REPEATS >= (1 << REP_CNT_W))) begin : g_bad_timing
    $error("ir_transmitter: inconsistent timing parameters");
  end

  ir_state_e              state;
  move_cmd_t              shadow;
  logic [UNIT_CNT_W-1:0]  unit_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [REP_CNT_W-1:0]   frames_sent;
  logic                   mark;
  logic                   cur_bit;
  logic [UNIT_CNT_W-1:0]  bit_last;

  // Length of the bit mark currently being sent
  assign cur_bit  = shadow[bit_idx];
  assign bit_last = cur_bit ? ONE_LAST : UNIT_LAST;

  // Frame sequencer: mark/space timing, bit walk, frame pacing and repeat count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= '0;
      unit_cnt    <= '0;
      frame_cnt   <= '0;
      bit_idx     <= '0;
      frames_sent <= '0;
      mark        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done      <= 1'b0;
      unit_cnt  <= unit_cnt + UNIT_CNT_W'(1);
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      case (state)
        IDLE: begin
          unit_cnt  <= '0;
          frame_cnt <= '0;
          if (transmit) begin
            state       <= START_MARK;
            shadow      <= move_command;
            bit_idx     <= '0;
            frames_sent <= '0;
            mark        <= 1'b1;
            busy        <= 1'b1;
          end
        end
        START_MARK: begin
          if (unit_cnt == START_LAST) begin
            state    <= SPACE;
            mark     <= 1'b0;
            unit_cnt <= '0;
          end
        end
        SPACE: begin
          if (unit_cnt == UNIT_LAST) begin
            unit_cnt <= '0;
            if (bit_idx != ALL_BITS) begin
              state <= BIT_MARK;
              mark  <= 1'b1;
            end else begin
              state <= FRAME_GAP;
            end
          end
        end
        BIT_MARK: begin
          if (unit_cnt == bit_last) begin
            state    <= SPACE;
            mark     <= 1'b0;
            unit_cnt <= '0;
            bit_idx  <= bit_idx + BIT_IDX_W'(1);
          end
        end
        FRAME_GAP: begin
          // Gap can outlast the unit counter range, so only the frame counter runs here
          unit_cnt <= '0;
          if (frame_cnt == FRAME_LAST) begin
            if (frames_sent == LAST_REP) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state       <= START_MARK;
              frames_sent <= frames_sent + REP_CNT_W'(1);
              frame_cnt   <= '0;
              bit_idx     <= '0;
              mark        <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          mark  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clock  (clock),
    .reset  (reset),
    .run    (mark),
    .carrier(ir_signal)
  );

endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench for ir_transmitter using scaled timing and a timeline reference model.
module tb_ir_transmitter;

  localparam int unsigned HZ      = 1_000_000;
  localparam int unsigned T       = 20;
  localparam int unsigned H       = 3;
  localparam int unsigned F       = 1000;
  localparam int unsigned R       = 3;
  localparam int unsigned CMD_LEN = R * F;

  logic        clock;
  logic        reset;
  logic        transmit;
  logic [11:0] move_command;
  logic        ir_signal;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;

  ir_transmitter #(
    .CLOCK_HZ    (HZ),
    .UNIT_CYCLES (T),
    .CARRIER_HALF(H),
    .FRAME_CYCLES(F),
    .REPEATS     (R)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .transmit    (transmit),
    .move_command(move_command),
    .ir_signal   (ir_signal),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected LED drive at cycle c of a frame, walking the frame timeline segment by segment
  function automatic bit model_ir(input logic [11:0] w, input int unsigned c);
    int unsigned t;
    int unsigned len;
    if (c < 4 * T) return ((c / H) % 2) == 0;
    t = 4 * T;
    if (c < t + T) return 1'b0;
    t = t + T;
    for (int b = 0; b < 12; b++) begin
      len = w[4'(b)] ? 2 * T : T;
      if (c < t + len) return (((c - t) / H) % 2) == 0;
      t = t + len;
      if (c < t + T) return 1'b0;
      t = t + T;
    end
    return 1'b0;
  endfunction

  // Start a command and compare ir_signal/busy/done over `cycles` cycles against the model
  task automatic run_command(input string name, input logic [11:0] w, input bit hold,
                             input int glitch_at, input int cycles,
                             output int rises, output int busy_cycles,
                             output int done_pulses, output int done_at);
    int  bad_ir = -1;
    int  bad_busy = -1;
    int  bad_done = -1;
    bit  got_ir = 1'b0, got_busy = 1'b0, got_done = 1'b0;
    bit  exp_ir_v = 1'b0, exp_busy_v = 1'b0, exp_done_v = 1'b0;
    bit  e_ir, e_busy, e_done;
    logic prev_ir = 1'b0;
    int  p;
    rises = 0; busy_cycles = 0; done_pulses = 0; done_at = -1;
    @(negedge clock);
    transmit = 1'b1;
    move_command = w;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      p = hold ? (i % int'(CMD_LEN + 1)) : i;
      if (p < int'(CMD_LEN)) begin
        e_busy = 1'b1; e_done = 1'b0; e_ir = model_ir(w, p % F);
      end else if (p == int'(CMD_LEN)) begin
        e_busy = 1'b0; e_done = 1'b1; e_ir = 1'b0;
      end else begin
        e_busy = 1'b0; e_done = 1'b0; e_ir = 1'b0;
      end
      if (ir_signal !== e_ir && bad_ir < 0) begin
        bad_ir = i; got_ir = ir_signal; exp_ir_v = e_ir;
      end
      if (busy !== e_busy && bad_busy < 0) begin
        bad_busy = i; got_busy = busy; exp_busy_v = e_busy;
      end
      if (done !== e_done && bad_done < 0) begin
        bad_done = i; got_done = done; exp_done_v = e_done;
      end
      if (ir_signal === 1'b1 && prev_ir !== 1'b1) rises++;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        done_pulses++;
        if (done_at < 0) done_at = i;
      end
      prev_ir = ir_signal;
      if (!hold) begin
        transmit = (i == glitch_at);
        move_command = (i == glitch_at) ? 12'h0AA : 12'($urandom);
      end
    end
    n_cmp++;
    if (bad_ir >= 0) begin
      n_bad++;
      $display("FAIL %s ir_signal: cycle %0d got %b want %b", name, bad_ir, got_ir, exp_ir_v);
    end
    n_cmp++;
    if (bad_busy >= 0) begin
      n_bad++;
      $display("FAIL %s busy: cycle %0d got %b want %b", name, bad_busy, got_busy, exp_busy_v);
    end
    n_cmp++;
    if (bad_done >= 0) begin
      n_bad++;
      $display("FAIL %s done: cycle %0d got %b want %b", name, bad_done, got_done, exp_done_v);
    end
  endtask

  task automatic test_reset();
    int active;
    reset = 1'b1;
    transmit = 1'b0;
    move_command = 12'h000;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (ir_signal !== 1'b0) begin
      n_bad++; $display("FAIL reset_ir: got %b want 0", ir_signal);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: got %b want 0", done);
    end
    reset = 1'b0;
    active = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ir_signal !== 1'b0 || busy !== 1'b0 || done !== 1'b0) active++;
    end
    n_cmp++;
    if (active !== 0) begin
      n_bad++; $display("FAIL post_reset_idle: active cycles %0d want 0", active);
    end
  endtask

  task automatic test_known_005();
    int rises, bc, dp, da;
    run_command("cmd005", 12'h005, 1'b0, -1, CMD_LEN + 50, rises, bc, dp, da);
    // per frame: 4T mark 14 pulses, 2T marks 7, T marks 4 -> 14+7+4+7+9*4 = 68
    n_cmp++;
    if (rises !== 204) begin
      n_bad++; $display("FAIL cmd005_pulses: got %0d want 204", rises);
    end
  endtask

  task automatic test_all_ones();
    int rises, bc, dp, da;
    run_command("cmdFFF", 12'hFFF, 1'b0, -1, CMD_LEN + 50, rises, bc, dp, da);
    n_cmp++;
    if (bc !== int'(CMD_LEN)) begin
      n_bad++; $display("FAIL cmdFFF_busy_len: got %0d want %0d", bc, CMD_LEN);
    end
    n_cmp++;
    if (dp !== 1) begin
      n_bad++; $display("FAIL cmdFFF_done_count: got %0d want 1", dp);
    end
    n_cmp++;
    if (da !== int'(CMD_LEN)) begin
      n_bad++; $display("FAIL cmdFFF_done_at: got %0d want %0d", da, CMD_LEN);
    end
  endtask

  task automatic test_random();
    int rises, bc, dp, da;
    logic [11:0] w;
    for (int k = 0; k < 4; k++) begin
      w = 12'($urandom);
      run_command($sformatf("rand%0d_%03h", k, w), w, 1'b0, -1, CMD_LEN + 20, rises, bc, dp, da);
    end
  endtask

  task automatic test_ignore_busy();
    int rises, bc, dp, da;
    run_command("ignore_busy", 12'h005, 1'b0, 1500, CMD_LEN + 1100, rises, bc, dp, da);
  endtask

  task automatic test_reset_mid_mark();
    int  active;
    bit  e_ir;
    @(negedge clock);
    transmit = 1'b1;
    move_command = 12'hFFF;
    for (int i = 0; i <= 112; i++) begin
      @(negedge clock);
      if (i == 0) transmit = 1'b0;
    end
    // cycle 112 is 12 cycles into the first bit mark
    e_ir = model_ir(12'hFFF, 112);
    n_cmp++;
    if (ir_signal !== e_ir || busy !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: ir %b busy %b want ir %b busy 1", ir_signal, busy, e_ir);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (ir_signal !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_ir: got %b want 0", ir_signal);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_busy: got %b want 0", busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    active = 0;
    for (int i = 0; i < int'(CMD_LEN + 200); i++) begin
      @(negedge clock);
      if (ir_signal !== 1'b0 || busy !== 1'b0 || done !== 1'b0) active++;
    end
    n_cmp++;
    if (active !== 0) begin
      n_bad++; $display("FAIL reset_quiet: active cycles %0d want 0", active);
    end
  endtask

  task automatic test_back_to_back();
    int  rises, bc, dp, da;
    bit  seen = 1'b0;
    run_command("back_to_back", 12'h3C5, 1'b1, -1, 2 * (CMD_LEN + 1) + 50, rises, bc, dp, da);
    transmit = 1'b0;
    for (int k = 0; k < int'(CMD_LEN + 10); k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL b2b_final_done: timeout waiting for done");
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || ir_signal !== 1'b0) begin
      n_bad++; $display("FAIL b2b_stop: busy %b ir %b want 0 0", busy, ir_signal);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_known_005();
    test_all_ones();
    test_random();
    test_ignore_busy();
    test_reset_mid_mark();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_transmitter.md
IR_TRANSMITTER -- requirements
Module: ir_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 27000000, system clock frequency.
REQ-002 SHALL have parameter UNIT_CYCLES, default 16200, one 0.6 ms protocol unit T.
REQ-003 SHALL have parameter CARRIER_HALF, default 338, carrier half-period in cycles (about 40 kHz).
REQ-004 SHALL have parameter FRAME_CYCLES, default 1215000, frame start-to-start period (45 ms).
REQ-005 SHALL have parameter REPEATS, default 3, frames sent per command.
REQ-006 SHALL have port clock  input  1  system clock; one clock, all logic on posedge clock.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port transmit  input  1  start request, sampled only in IDLE.
REQ-009 SHALL have port move_command  input  12  command word from main_fsm; [7:0] magnitude, [11:8] angle.
REQ-010 SHALL have port ir_signal  output  1  modulated drive to the IR LED.
REQ-011 SHALL have port busy  output  1  high while a command is being sent.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the last frame ends.

Function
REQ-013 SHALL leave IDLE on transmit=1, latching move_command into an internal shadow register; busy=1 and the START_MARK begins in the next cycle.
REQ-014 SHALL ignore transmit and move_command changes while busy=1; the latched word is used for all REPEATS frames.
REQ-015 SHALL use states IDLE, START_MARK, SPACE, BIT_MARK, FRAME_GAP.
REQ-016 START_MARK SHALL last 4T and then go to SPACE.
REQ-017 SPACE SHALL last T and then go to BIT_MARK while bits remain, otherwise to FRAME_GAP.
REQ-018 BIT_MARK SHALL send bits LSB first (bit 0 to bit 11), lasting 2T for a 1 and T for a 0, then go to SPACE.
REQ-019 FRAME_GAP SHALL hold ir_signal=0 until FRAME_CYCLES cycles have passed since that frame's START_MARK began.
REQ-020 At the end of FRAME_GAP, SHALL start the next START_MARK if frames sent < REPEATS, else return to IDLE.
REQ-021 On return to IDLE, SHALL pulse done for one cycle and drop busy in that same cycle.
REQ-022 ir_signal SHALL equal the carrier during START_MARK and BIT_MARK, and 0 in every other state.
REQ-023 The carrier SHALL restart high at the first cycle of each mark and toggle every CARRIER_HALF cycles.
REQ-024 The frame counter SHALL be 21 bits, the unit counter 16 bits and the bit index 4 bits; counters SHALL never wrap within a frame.
REQ-025 A worst-case frame (all ones, 41T = 664200 cycles) SHALL fit within FRAME_CYCLES; no overrun handling is needed.
REQ-026 transmit held high across the done cycle SHALL start a new command only from IDLE, i.e. on the cycle after done.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, ir_signal=0, busy=0, done=0, and clear all counters and the shadow register, including mid-frame.
REQ-028 After reset is released, the block SHALL stay in IDLE until a fresh transmit.

Structure
REQ-029 The shared package SHALL hold the state encoding and the timing constants (UNIT_CYCLES, CARRIER_HALF, FRAME_CYCLES, REPEATS) for 27 MHz.
REQ-030 ir_carrier_gen SHALL be a single sub-module with inputs clock, reset and run; output carrier; phase restart on run rising.

Verification
REQ-031 Send move_command=12'h005 with transmit pulsed: ir_signal burst envelopes SHALL be 64800, 32400, 16200, 32400, then nine of 16200 cycles; each followed by a 16200-cycle gap; 3 frames.
REQ-032 Send 12'hFFF: busy SHALL be high for exactly 3645000 cycles, with one done pulse on the cycle busy falls.
REQ-033 During any mark, ir_signal SHALL have a period of 676 cycles and start high.
REQ-034 Pulse transmit with 12'h0AA while busy with 12'h005: the frames SHALL remain 12'h005, and no extra frames SHALL follow.
REQ-035 Assert reset 100 cycles into BIT_MARK: ir_signal and busy SHALL be 0 before the next edge, and there SHALL be no output until the next transmit.
REQ-036 Hold transmit high continuously: back-to-back commands SHALL start one cycle after each done.
